// File: rtl/aes_host_pkg.sv
// ============================================================================
// Module      : aes_host_pkg
// Description : Shared types and helpers for the bit-serial AES host.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_host_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        RECV = 3'd3,
        HOLD = 3'd4
    } host_state_e;

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_serial_host_if.sv
// ============================================================================
// Module      : aes_serial_host_if
// Description : Parallel request/result port of the AES serial host.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_serial_host_if
    import aes_host_pkg::*;
#(
    parameter int DATA_W = AES_BLOCK_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] in_key;
    logic              in_decrypt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_key, in_decrypt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, in_decrypt, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

`default_nettype wire

// File: rtl/aes_host_shreg.sv
// ============================================================================
// Module      : aes_host_shreg
// Description : DATA_W shift register, parallel load, serial in at LSB,
//               full parallel view (MSB is the serial output).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_host_shreg
    import aes_host_pkg::*;
#(
    parameter int DATA_W = AES_BLOCK_W
) (
    input  wire               clk,
    input  wire               rst_n,
    input  wire               i_load,
    input  wire  [DATA_W-1:0] i_din,
    input  wire               i_shift,
    input  wire               i_ser,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    // Load wins over shift so a new request can never be corrupted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_din;
        end else if (i_shift) begin
            r_q <= {r_q[DATA_W-2:0], i_ser};
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/aes_serial_host.sv
// ============================================================================
// Module      : aes_serial_host
// Description : Host initiator for the bit-serial AES core: serializes block
//               and key, waits for done, deserializes the result.
//               Optional WAIT watchdog enabled by AES_HOST_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_serial_host
    import aes_host_pkg::*;
#(
    parameter int DATA_W         = AES_BLOCK_W,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire               clk,
    input  wire               rst_n,
    aes_serial_host_if.slave  bus,
    output logic              err,
    output logic              aes_data_bit,
    output logic              aes_key_bit,
    output logic              aes_start,
    output logic              aes_decrypt,
    input  wire               aes_data_out_bit,
    input  wire               aes_busy,
    input  wire               aes_done
);

    localparam int                 c_cnt_w    = cnt_width(DATA_W);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);

    host_state_e        r_state;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic               r_rdy_en;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_tx_shift;
    logic               w_rx_shift;
    logic [DATA_W-1:0]  w_tx_q;
    logic [DATA_W-1:0]  w_key_q;
    logic [DATA_W-1:0]  w_rx_q;
    logic               w_unused_low;

`ifdef AES_HOST_TIMEOUT_EN
    localparam int                c_to_w    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

    logic [c_to_w-1:0] r_to_cnt;
    logic              r_err;

    assign err = r_err;
`else
    localparam int c_timeout_unused = TIMEOUT_CYCLES;

    assign err = 1'b0;
`endif

    // r_rdy_en keeps in_ready low through reset and rises the cycle after release.
    assign bus.in_ready  = (r_state == IDLE) && r_rdy_en && !aes_busy;
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_tx_shift    = (r_state == SEND);
    assign w_rx_shift    = (r_state == RECV);

    assign aes_data_bit  = w_tx_shift && w_tx_q[DATA_W-1];
    assign aes_key_bit   = w_tx_shift && w_key_q[DATA_W-1];
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = w_rx_q;
    assign w_unused_low  = ^{w_tx_q[DATA_W-2:0], w_key_q[DATA_W-2:0]};

    aes_host_shreg #(.DATA_W(DATA_W)) u_tx_data (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_din   (bus.in_data),
        .i_shift (w_tx_shift),
        .i_ser   (1'b0),
        .o_q     (w_tx_q)
    );

    aes_host_shreg #(.DATA_W(DATA_W)) u_tx_key (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_din   (bus.in_key),
        .i_shift (w_tx_shift),
        .i_ser   (1'b0),
        .o_q     (w_key_q)
    );

    aes_host_shreg #(.DATA_W(DATA_W)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (1'b0),
        .i_din   ({DATA_W{1'b0}}),
        .i_shift (w_rx_shift),
        .i_ser   (aes_data_out_bit),
        .o_q     (w_rx_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_rdy_en    <= 1'b0;
            r_out_valid <= 1'b0;
            aes_start   <= 1'b0;
            aes_decrypt <= 1'b0;
`ifdef AES_HOST_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_rdy_en  <= 1'b1;
            aes_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        aes_decrypt <= bus.in_decrypt;
                        aes_start   <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_state     <= SEND;
`ifdef AES_HOST_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                    end
                end
                SEND: begin
                    if (r_bit_cnt == c_last_bit) begin
                        r_bit_cnt <= '0;
                        r_state   <= WAIT;
`ifdef AES_HOST_TIMEOUT_EN
                        r_to_cnt  <= '0;
`endif
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (aes_done) begin
                        r_bit_cnt <= '0;
                        r_state   <= RECV;
                    end
`ifdef AES_HOST_TIMEOUT_EN
                    else if (r_to_cnt == c_to_last) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                RECV: begin
                    if (r_bit_cnt == c_last_bit) begin
                        r_bit_cnt   <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/aes_serial_host.md
# aes_serial_host

- Host-side initiator for the bit-serial AES core interface:
  - accepts a 128-bit block, key and direction on a parallel valid/ready port;
  - serializes block and key onto the core's data/key bit lines and pulses start;
  - waits for done, deserializes the 128-bit result and presents it on a parallel valid/ready port.
- Sits between an on-chip controller (or test harness) and the AES core, on the core clock domain.

## Interface
Parameters:
- DATA_W, 128, block and key width in bits; power of two, at least 8.
- TIMEOUT_CYCLES, 4096, maximum cycles waited for done; used only with the watchdog (see Configuration).

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.

| Name | Direction | Width | Meaning |
|---|---|---|---|
| clk | in | 1 | sole clock; all logic on rising edge |
| rst_n | in | 1 | synchronous active-low reset |
| in_valid | in | 1 | request valid |
| in_ready | out | 1 | request accepted when in_valid && in_ready |
| in_data | in | DATA_W | plaintext/ciphertext block |
| in_key | in | DATA_W | key |
| in_decrypt | in | 1 | 1 = decrypt, 0 = encrypt |
| out_valid | out | 1 | result valid, held until accepted |
| out_ready | in | 1 | result consumer ready |
| out_data | out | DATA_W | result block |
| err | out | 1 | sticky timeout flag |
| aes_data_bit | out | 1 | serial data to core |
| aes_key_bit | out | 1 | serial key to core |
| aes_start | out | 1 | one-cycle start pulse to core |
| aes_decrypt | out | 1 | direction to core |
| aes_data_out_bit | in | 1 | serial result from core |
| aes_busy | in | 1 | core busy status |
| aes_done | in | 1 | core done pulse |

## Operation
FSM states:
- IDLE:
  - in_ready = !aes_busy.
  - On accept: latch in_data into TX shift register, in_key into key shift register, in_decrypt into aes_decrypt; clear err; go to SEND.
- SEND, DATA_W cycles, bit counter 0..DATA_W-1:
  - aes_start = 1 only in the first SEND cycle.
  - aes_data_bit / aes_key_bit = MSB of the respective shift register each cycle; registers shift left by one per cycle.
  - After DATA_W cycles, go to WAIT.
- WAIT:
  - On aes_done = 1, go to RECV.
  - aes_done seen in any state other than WAIT is ignored.
- RECV, DATA_W cycles:
  - Each cycle shift aes_data_out_bit into the LSB of the RX register, so the first received bit ends up as the MSB.
  - After DATA_W cycles, go to HOLD.
- HOLD:
  - out_valid = 1 and out_data = RX register, both stable.
  - On out_ready, go to IDLE.

Other rules:
- aes_decrypt stays constant from accept until HOLD exits.
- Serial outputs are 0 outside SEND.
- Reset mid-operation aborts immediately. All outputs return to 0 the cycle after rst_n is sampled low, including in_ready, out_valid, err, aes_* and out_data; state goes to IDLE.
  - in_ready rises again the first cycle after release, provided aes_busy = 0.
- Counters are $clog2(DATA_W) bits wide. Terminal count is DATA_W-1; no wrap beyond it.

## Timing
- Accept in cycle A. Then:
  - aes_start and the MSBs of data and key are driven in cycle A+1.
  - Bit k is driven in cycle A+1+k; the last bit is in A+DATA_W.
- aes_done sampled high in cycle D:
  - Result bit k is sampled in cycle D+1+k.
  - out_valid rises in cycle D+DATA_W+1.
- Latency from accept to out_valid = DATA_W + core latency + DATA_W + 1 cycles.
- aes_done in the same cycle the last SEND bit is driven is ignored. Done is only honored from WAIT.
- out_valid && out_ready in cycle H: out_valid drops in H+1, and in_ready can be 1 in H+1.
- No request overlap: in_ready = 0 whenever state != IDLE.

## Configuration
- AES_HOST_TIMEOUT_EN defined: WAIT has a cycle counter.
  - If TIMEOUT_CYCLES cycles elapse without aes_done, set err = 1 and go to IDLE; no out_valid is produced.
  - err holds until the next accept or reset.
- Not defined: WAIT waits indefinitely. err is tied to 0 and no timeout counter is instantiated.

## Structure
- Package aes_host_pkg holds:
  - the state enum (IDLE, SEND, WAIT, RECV, HOLD);
  - localparam AES_BLOCK_W = 128;
  - the counter-width helper.
- One sub-module: aes_host_shreg, a parameterized DATA_W shift register with parallel load, serial-in and MSB serial-out.
  - Instantiated three times: TX data, TX key and RX.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles mid-SEND → all outputs 0 next cycle; in_ready = 1 after release with aes_busy = 0.
- Serialization: in_data = 0x8000…0001, in_key = 0xFFFF…0000 → aes_start in A+1 only; data bit 1 at A+1 and at A+128; key bits 1 for A+1..A+64, then 0.
- Round trip: core model pulses done 20 cycles after the last bit, then streams 0x0123…CDEF → out_data = 0x0123…CDEF, out_valid at D+129.
- Backpressure: out_ready = 0 for 10 cycles → out_valid and out_data stable; in_ready stays 0 until the cycle after the handshake.
- Stray done and busy: done pulsed during SEND is ignored (no early RECV); aes_busy = 1 in IDLE → in_ready = 0.
- Timeout (AES_HOST_TIMEOUT_EN, TIMEOUT_CYCLES = 16): no done → err = 1 and state IDLE 16 cycles after WAIT entry; next accept clears err.
